// File: rtl/mem_access_unit.sv
// Load/store unit bridging the core memory port to a variable-latency word memory.
// Handles request/response handshake, lane steering, load extension, misalignment and timeout.
module mem_access_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_adr,
    input  logic [31:0]       core_wdata,
    input  logic [2:0]        core_funct3,
    output logic [31:0]       core_rdata,
    output logic              core_done,
    output logic              core_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        lane_q, lane_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              illegal_c, misalign_c;

    // Select the addressed lane of a read word and sign/zero-extend it.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        illegal_c = (core_funct3 == 3'b011) || (core_funct3 == 3'b110) ||
                    (core_funct3 == 3'b111) || (core_we && core_funct3[2]);
        case (core_funct3[1:0])
            2'b01:   misalign_c = core_adr[0];
            2'b10:   misalign_c = (core_adr[1:0] != 2'b00);
            default: misalign_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        lane_d      = lane_q;
        funct3_d    = funct3_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    we_d     = core_we;
                    lane_d   = core_adr[1:0];
                    funct3_d = core_funct3;
                    if (illegal_c || misalign_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        mem_valid_d = 1'b1;
                        mem_we_d    = core_we;
                        mem_adr_d   = {core_adr[ADDR_W-1:2], 2'b00};
                        if (!core_we) begin
                            mem_wdata_d = 32'd0;
                            mem_be_d    = 4'b1111;
                        end else begin
                            case (core_funct3[1:0])
                                2'b00: begin
                                    mem_wdata_d = {4{core_wdata[7:0]}};
                                    mem_be_d    = 4'b0001 << core_adr[1:0];
                                end
                                2'b01: begin
                                    mem_wdata_d = {2{core_wdata[15:0]}};
                                    mem_be_d    = core_adr[1] ? 4'b1100 : 4'b0011;
                                end
                                default: begin
                                    mem_wdata_d = core_wdata;
                                    mem_be_d    = 4'b1111;
                                end
                            endcase
                        end
                    end
                end
            end
            S_REQ: begin
                // Completion has priority over a coincident timeout.
                if (mem_ready && (we_q || mem_rvalid)) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    mem_valid_d = 1'b0;
                    if (!we_q) rdata_d = load_ext(mem_rdata, lane_q, funct3_q);
                end else if (cnt_q == TO_LAST) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    fault_d     = 1'b1;
                    mem_valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                    if (mem_ready) begin
                        state_d     = S_WAIT;
                        mem_valid_d = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdata_d = load_ext(mem_rdata, lane_q, funct3_q);
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            lane_q      <= 2'd0;
            funct3_q    <= 3'd0;
            cnt_q       <= '0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            lane_q      <= lane_d;
            funct3_q    <= funct3_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign core_rdata = rdata_q;
    assign core_done  = done_q;
    assign core_fault = fault_q;
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_adr    = mem_adr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default-timeout instance plus a TIMEOUT=4 instance.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        core_req, core_we;
    logic [31:0] core_adr, core_wdata;
    logic [2:0]  core_funct3;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic [31:0] rdata_a, rdata_b, adr_a, adr_b, wdata_a, wdata_b;
    logic        done_a, done_b, fault_a, fault_b, valid_a, valid_b, we_a, we_b;
    logic [3:0]  be_a, be_b;

    logic [31:0] o_rdata, o_adr, o_wdata;
    logic        o_done, o_fault, o_valid, o_we;
    logic [3:0]  o_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit u_dut_a (
        .clk(clk), .rst(rst), .core_req(core_req & ~sel), .core_we(core_we),
        .core_adr(core_adr), .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(rdata_a), .core_done(done_a), .core_fault(fault_a),
        .mem_valid(valid_a), .mem_ready(mem_ready), .mem_we(we_a), .mem_adr(adr_a),
        .mem_wdata(wdata_a), .mem_be(be_a), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    mem_access_unit #(.TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst(rst), .core_req(core_req & sel), .core_we(core_we),
        .core_adr(core_adr), .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(rdata_b), .core_done(done_b), .core_fault(fault_b),
        .mem_valid(valid_b), .mem_ready(mem_ready), .mem_we(we_b), .mem_adr(adr_b),
        .mem_wdata(wdata_b), .mem_be(be_b), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    assign o_rdata = sel ? rdata_b : rdata_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_fault = sel ? fault_b : fault_a;
    assign o_valid = sel ? valid_b : valid_a;
    assign o_we    = sel ? we_b    : we_a;
    assign o_adr   = sel ? adr_b   : adr_a;
    assign o_wdata = sel ? wdata_b : wdata_a;
    assign o_be    = sel ? be_b    : be_a;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a request for one cycle; returns at the sample point of the following cycle.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [2:0] f3);
        core_req    = 1'b1;
        core_we     = we;
        core_adr    = adr;
        core_wdata  = wd;
        core_funct3 = f3;
        step();
        core_req = 1'b0;
    endtask

    // Check every output against its reset value.
    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rdata"}, o_rdata, 32'd0);
        check_eq({tag, "_done"},  32'(o_done), 32'd0);
        check_eq({tag, "_fault"}, 32'(o_fault), 32'd0);
        check_eq({tag, "_valid"}, 32'(o_valid), 32'd0);
        check_eq({tag, "_we"},    32'(o_we), 32'd0);
        check_eq({tag, "_adr"},   o_adr, 32'd0);
        check_eq({tag, "_wdata"}, o_wdata, 32'd0);
        check_eq({tag, "_be"},    32'(o_be), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; core_req = 1'b0; core_we = 1'b0; core_adr = 32'd0;
        core_wdata = 32'd0; core_funct3 = 3'd0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        step(); step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // SW zero-wait
        mem_ready = 1'b1;
        issue(1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
        check_eq("sw_valid", 32'(o_valid), 32'd1);
        check_eq("sw_we",    32'(o_we), 32'd1);
        check_eq("sw_be",    32'(o_be), 32'hF);
        check_eq("sw_adr",   o_adr, 32'h100);
        check_eq("sw_wdata", o_wdata, 32'hDEADBEEF);
        check_eq("sw_done_early", 32'(o_done), 32'd0);
        step();
        check_eq("sw_done",  32'(o_done), 32'd1);
        check_eq("sw_fault", 32'(o_fault), 32'd0);
        check_eq("sw_valid_drop", 32'(o_valid), 32'd0);
        step();
        check_eq("sw_done_pulse", 32'(o_done), 32'd0);

        // SB to byte lane 3
        issue(1'b1, 32'h103, 32'h000000A5, 3'b000);
        check_eq("sb_wdata", o_wdata, 32'hA5A5A5A5);
        check_eq("sb_be",    32'(o_be), 32'h8);
        step();
        check_eq("sb_done",  32'(o_done), 32'd1);
        check_eq("sb_rdata_kept", o_rdata, 32'd0);
        step();

        // LB / LBU from lane 3 with data returned alongside ready
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF7F01;
        issue(1'b0, 32'h103, 32'd0, 3'b000);
        check_eq("lb_we",    32'(o_we), 32'd0);
        check_eq("lb_be",    32'(o_be), 32'hF);
        check_eq("lb_wdata", o_wdata, 32'd0);
        check_eq("lb_adr",   o_adr, 32'h100);
        step();
        check_eq("lb_done",  32'(o_done), 32'd1);
        check_eq("lb_rdata", o_rdata, 32'hFFFFFF80);
        step();
        issue(1'b0, 32'h103, 32'd0, 3'b100);
        step();
        check_eq("lbu_done",  32'(o_done), 32'd1);
        check_eq("lbu_rdata", o_rdata, 32'h00000080);
        step();

        // LH upper half with 3 ready stalls and rvalid 2 cycles after ready
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h80011234;
        issue(1'b0, 32'h102, 32'd0, 3'b001);
        for (int i = 0; i < 3; i++) begin
            check_eq("lh_stall_valid", 32'(o_valid), 32'd1);
            check_eq("lh_stall_adr",   o_adr, 32'h100);
            check_eq("lh_stall_be",    32'(o_be), 32'hF);
            check_eq("lh_stall_we",    32'(o_we), 32'd0);
            step();
        end
        check_eq("lh_ready_valid", 32'(o_valid), 32'd1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("lh_wait_valid", 32'(o_valid), 32'd0);
        check_eq("lh_wait_done",  32'(o_done), 32'd0);
        step();
        check_eq("lh_wait_done2", 32'(o_done), 32'd0);
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check_eq("lh_done",  32'(o_done), 32'd1);
        check_eq("lh_fault", 32'(o_fault), 32'd0);
        check_eq("lh_rdata", o_rdata, 32'hFFFF8001);
        step();

        // Faulting requests: misaligned LW, misaligned SH, illegal funct3
        issue(1'b0, 32'h101, 32'd0, 3'b010);
        check_eq("lw_mis_done",  32'(o_done), 32'd1);
        check_eq("lw_mis_fault", 32'(o_fault), 32'd1);
        check_eq("lw_mis_valid", 32'(o_valid), 32'd0);
        check_eq("lw_mis_rdata", o_rdata, 32'hFFFF8001);
        step();
        check_eq("lw_mis_valid2", 32'(o_valid), 32'd0);
        issue(1'b1, 32'h003, 32'h1234, 3'b001);
        check_eq("sh_mis_fault", 32'(o_fault), 32'd1);
        check_eq("sh_mis_valid", 32'(o_valid), 32'd0);
        step();
        issue(1'b0, 32'h100, 32'd0, 3'b011);
        check_eq("f3_ill_done",  32'(o_done), 32'd1);
        check_eq("f3_ill_fault", 32'(o_fault), 32'd1);
        check_eq("f3_ill_valid", 32'(o_valid), 32'd0);
        check_eq("f3_ill_rdata", o_rdata, 32'hFFFF8001);
        step();

        // Timeout on the TIMEOUT=4 instance
        sel       = 1'b1;
        mem_ready = 1'b1;
        step();
        issue(1'b0, 32'h200, 32'd0, 3'b010);
        check_eq("to_valid", 32'(o_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("to_no_done", 32'(o_done), 32'd0);
        end
        step();
        check_eq("to_done",  32'(o_done), 32'd1);
        check_eq("to_fault", 32'(o_fault), 32'd1);
        check_eq("to_valid_drop", 32'(o_valid), 32'd0);
        check_eq("to_rdata", o_rdata, 32'd0);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        step();
        mem_rvalid = 1'b0;
        step();
        check_eq("late_rv_done",  32'(o_done), 32'd0);
        check_eq("late_rv_rdata", o_rdata, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        issue(1'b0, 32'h204, 32'd0, 3'b010);
        step();
        check_eq("to_next_done",  32'(o_done), 32'd1);
        check_eq("to_next_fault", 32'(o_fault), 32'd0);
        check_eq("to_next_rdata", o_rdata, 32'hCAFEF00D);
        mem_rvalid = 1'b0;
        step();

        // Reset while waiting for read data
        sel = 1'b0;
        step();
        issue(1'b0, 32'h108, 32'd0, 3'b010);
        step();
        check_eq("rst_wait_valid", 32'(o_valid), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("rst_wait");
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check_eq("rst_no_done", 32'(o_done), 32'd0);
        check_eq("rst_rdata",   o_rdata, 32'd0);

        // Request held high through DONE is not re-accepted until IDLE
        core_req    = 1'b1;
        core_we     = 1'b1;
        core_adr    = 32'h10;
        core_wdata  = 32'h11223344;
        core_funct3 = 3'b010;
        step();
        check_eq("hold_valid1", 32'(o_valid), 32'd1);
        step();
        check_eq("hold_done",   32'(o_done), 32'd1);
        check_eq("hold_valid_done", 32'(o_valid), 32'd0);
        step();
        check_eq("hold_idle_valid", 32'(o_valid), 32'd0);
        check_eq("hold_idle_done",  32'(o_done), 32'd0);
        step();
        core_req = 1'b0;
        check_eq("hold_reaccept", 32'(o_valid), 32'd1);
        step();
        check_eq("hold_done2", 32'(o_done), 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit between the multicycle `riscv` core's memory port and a variable-latency, word-organised data memory. It replaces the fixed single-cycle, funct3-passthrough memory contract with a registered request/response handshake. It also does byte/halfword lane steering, byte enables, load sign/zero extension, misalignment detection and a bus timeout. The core's control unit holds its memory state until `core_done` pulses.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width (≥3).
- `TIMEOUT`, 255, max cycles waiting in REQ+WAIT before fault (≥2).
- `TO_W`, $clog2(TIMEOUT+1), timeout counter width.

Ports (clock is `clk`; reset is `rst`, synchronous and active-high):
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `core_req` in 1: access request, sampled only in IDLE.
- `core_we` in 1: 1 = store, 0 = load.
- `core_adr` in ADDR_W: byte address.
- `core_wdata` in 32: store data, lane 0 aligned.
- `core_funct3` in 3: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `core_rdata` out 32: extended load result, registered, held until next load completes.
- `core_done` out 1: one-cycle completion pulse.
- `core_fault` out 1: valid with `core_done`; 1 = misaligned/illegal/timeout.
- `mem_valid` out 1: request valid, held until `mem_ready`.
- `mem_ready` in 1: memory accepts request.
- `mem_we` out 1: write request.
- `mem_adr` out ADDR_W: word address, {core_adr[ADDR_W-1:2], 2'b00}.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data word.

## Operation
- States: IDLE, REQ, WAIT, DONE. All outputs are registered.
- IDLE + `core_req`: capture we/adr/wdata/funct3.
  - Legal and aligned → REQ.
  - Otherwise → DONE with fault=1. No memory request is issued.
- Illegal: funct3 ∈ {011,110,111}; store with funct3 ∉ {000,001,010}.
- Misaligned: H/HU with adr[0]=1; W with adr[1:0]≠00.
- REQ: `mem_valid`=1 with stable `mem_we`/`mem_adr`/`mem_wdata`/`mem_be` until `mem_ready`.
  - Store + ready → DONE.
  - Load + ready + rvalid in the same cycle → DONE, rdata captured.
  - Load + ready without rvalid → WAIT.
- WAIT: `mem_rvalid` → capture and extend data, then DONE.
- DONE: `core_done`=1 for exactly one cycle, then IDLE. `core_req` in DONE is ignored.
- Store steering:
  - SB: wdata[7:0] replicated ×4; be = 1<<adr[1:0].
  - SH: wdata[15:0] replicated ×2; be = adr[1] ? 1100 : 0011.
  - SW: be = 1111.
- Loads drive be=1111 and wdata=0.
- Load extension:
  - B/BU: byte lane adr[1:0], sign- or zero-extended.
  - H/HU: half lane adr[1], sign- or zero-extended.
  - W: full word.
- Timeout counter:
  - Cleared on entering REQ; increments each cycle in REQ/WAIT.
  - At count == TIMEOUT-1 with no completing event → DONE, fault=1, `mem_valid` dropped.
  - If completion and timeout fall in the same cycle, completion wins with fault=0.
- `mem_rvalid` outside WAIT/REQ is ignored, including a late response after timeout.
- `core_rdata` is unchanged by stores and faulted accesses.

## Timing
- Reset: state IDLE; `core_rdata`=0, `core_done`=0, `core_fault`=0, `mem_valid`=0, `mem_we`=0, `mem_adr`=0, `mem_wdata`=0, `mem_be`=0, counter=0.
- Reset mid-transaction aborts immediately. `mem_valid` is 0 the cycle after `rst` is sampled, and no `core_done` is issued.
- `core_req` at edge N → `mem_valid` high in cycle N+1.
- Zero-wait store (ready in N+1) → `core_done` in N+2. Latency is 2 cycles plus ready stalls.
- Load with rvalid in cycle M (M ≥ N+1) → `core_done` and `core_rdata` valid in M+1.
- Fault detected at request → `core_done`+`core_fault` in N+1.
- Back-to-back: the next `core_req` is accepted no earlier than the cycle after `core_done`. Minimum issue interval is 3 cycles.

## Test plan
- Reset, then SW adr 0x100, data 0xDEADBEEF, ready held high → `mem_valid` in N+1 with be=1111 and adr 0x100; done=1, fault=0 in N+2.
- SB adr 0x103, data 0x000000A5 → mem_wdata 0xA5A5A5A5, be=1000. Then LB adr 0x103 with rdata 0x80FF7F01 → core_rdata 0xFFFFFF80. LBU at the same address → 0x00000080.
- LH adr 0x102, rdata 0x8001_1234, ready stalled 3 cycles, rvalid 2 cycles after ready → core_rdata 0xFFFF8001. Verify request fields are stable during the stall; done comes 1 cycle after rvalid.
- LW adr 0x101 and SH adr 0x003 → done+fault in N+1, `mem_valid` never asserted, `core_rdata` unchanged. funct3=011 load → fault.
- Load with TIMEOUT=4 and rvalid never asserted → fault with done 4 cycles after REQ entry. A later rvalid is ignored, and the next LW completes normally.
- Assert rst in WAIT → `mem_valid`=0 and all outputs 0 the next cycle, no done pulse. `core_req` held high through DONE is not re-accepted until IDLE.
